// File: rtl/rs232_recv3_pkg.sv
// Shared definitions for the RS-232 receive path: FSM states and the
// rounded baud divisor used by both the receiver and transmitter.
package rs232_recv3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HI
  } rx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned rs232_div(input int unsigned clock_freq,
                                            input int unsigned baud_rate);
    return (clock_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/rs232_recv3_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; shared by the RS-232
// receive and transmit paths.
module rs232_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ABITS = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [ABITS:0]   count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 2 ** ABITS;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ABITS:0]   wr_ptr;
  logic [ABITS:0]   rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign count = wr_ptr - rd_ptr;
  // count never exceeds DEPTH, so its top bit alone marks full
  assign full  = count[ABITS];
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[ABITS-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[ABITS-1:0]];

endmodule

// File: rtl/rs232_recv3.sv
// RS-232 8N1 receiver: oversampled framing into a FWFT FIFO presented as a
// valid/ready stream, with CTS flow control back to the host.
module rs232_recv3 #(
  parameter int unsigned CLOCK_FREQ = 133000000,
  parameter int unsigned BAUD_RATE  = 12000000,
  parameter int unsigned FIFO_ABITS = 4,
  parameter int unsigned CTS_SLACK  = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rs232_txd,
  output logic       rs232_ctsn,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_error,
  output logic       overrun
);

  import rs232_recv3_pkg::*;

  localparam int unsigned DIV   = rs232_div(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned CW    = FIFO_ABITS + 1;
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CW-1:0]    DEPTH_L = CW'(2 ** FIFO_ABITS);
  localparam logic [CW-1:0]    SLACK_L = CW'(CTS_SLACK);

  if (DIV < 4) begin : g_div_check
    $error("rs232_recv3: clock/baud ratio too small");
  end

  logic             sync1, sync2, sync3;
  rx_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       idx, idx_nx;
  logic [7:0]       shreg, shreg_nx;
  logic             push_q, push_nx;
  logic             fe_nx;
  logic             tick;

  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    free_cnt;

  assign tick     = (cnt == '0);
  assign free_cnt = DEPTH_L - fifo_count;

  always_comb begin
    state_nx = state;
    cnt_nx   = tick ? cnt : cnt - 1'b1;
    idx_nx   = idx;
    shreg_nx = shreg;
    push_nx  = 1'b0;
    fe_nx    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sync3 && !sync2) begin
          state_nx = ST_START;
          cnt_nx   = HALF_M1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!sync2) begin
            state_nx = ST_DATA;
            idx_nx   = '0;
            cnt_nx   = DIV_M1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_nx[idx] = sync2;
          idx_nx        = idx + 1'b1;
          cnt_nx        = DIV_M1;
          if (idx == 3'd7) state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (sync2) begin
            push_nx  = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            fe_nx    = 1'b1;
            state_nx = ST_WAIT_HI;
          end
        end
      end
      ST_WAIT_HI: begin
        if (sync2) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // shreg is stable while push_q is high, so it feeds the FIFO directly
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      sync3       <= 1'b1;
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      push_q      <= 1'b0;
      frame_error <= 1'b0;
      rs232_ctsn  <= 1'b0;
    end else begin
      sync1       <= rs232_txd;
      sync2       <= sync1;
      sync3       <= sync2;
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      shreg       <= shreg_nx;
      push_q      <= push_nx;
      frame_error <= fe_nx;
      rs232_ctsn  <= (free_cnt <= SLACK_L);
    end
  end

  rs232_fifo #(
    .WIDTH (8),
    .ABITS (FIFO_ABITS)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .wr_data (shreg),
    .wr_en   (push_q),
    .rd_en   (ready),
    .rd_data (data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign valid   = !fifo_empty;
  assign overrun = push_q && fifo_full;

endmodule

// File: tb/tb_rs232_recv3.sv
// Directed bench for rs232_recv3: serial frames in, scoreboard of expected
// bytes checked against the valid/ready stream.
module tb_rs232_recv3;

  localparam int unsigned CLOCK_FREQ = 133000000;
  localparam int unsigned BAUD_RATE  = 12000000;
  localparam int unsigned FIFO_ABITS = 4;
  localparam int unsigned CTS_SLACK  = 4;
  localparam int unsigned DIV  = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned LAT  = 2 + HALF + 9 * DIV + 1;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       rs232_txd = 1'b1;
  logic       ready = 1'b0;
  logic       rs232_ctsn;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       overrun;

  rs232_recv3 #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_ABITS (FIFO_ABITS),
    .CTS_SLACK  (CTS_SLACK)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .rs232_txd   (rs232_txd),
    .rs232_ctsn  (rs232_ctsn),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0]  sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_beats  = 0;
  int          n_fe     = 0;
  int          n_ov     = 0;
  int unsigned last_beat_cyc = 0;
  int unsigned t_start = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (resetn) begin
      if (frame_error) n_fe++;
      if (overrun) n_ov++;
      if (frame_error || overrun)
        check("fe_ov_exclusive", {31'b0, frame_error && overrun}, 32'd0);
      if (valid && ready) begin
        n_beats++;
        last_beat_cyc = cyc;
        check("beat_expected", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) check("beat_data", {24'b0, data}, {24'b0, sb.pop_front()});
      end
    end
  end

  task automatic hold(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] b);
    rs232_txd = 1'b0;
    t_start = cyc;
    hold(DIV);
    for (int i = 0; i < 8; i++) begin
      rs232_txd = b[i];
      hold(DIV);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int unsigned stop_clks);
    start_frame(b);
    rs232_txd = stop;
    hold(stop_clks);
    rs232_txd = 1'b1;
    hold(2);
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      hold(1);
      if (!valid) break;
    end
    hold(2);
  endtask

  int beats0;
  int fe0;
  int ov0;

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_ctsn", {31'b0, rs232_ctsn}, 32'd0);
    check("rst_fe", {31'b0, frame_error}, 32'd0);
    check("rst_ov", {31'b0, overrun}, 32'd0);
    resetn = 1'b1;
    hold(5);

    // 0x55 with latency
    ready = 1'b1;
    sb.push_back(8'h55);
    send_byte(8'h55, 1'b1, DIV);
    hold(20);
    check("latency", last_beat_cyc - t_start - 1, LAT);
    check("beats_55", n_beats, 1);
    check("sb_empty_55", sb.size(), 0);
    check("no_err_55", n_fe + n_ov, 0);

    // idle glitch then 0xA3
    rs232_txd = 1'b0;
    hold(3);
    rs232_txd = 1'b1;
    hold(25);
    check("glitch_beats", n_beats, 1);
    check("glitch_fe", n_fe, 0);
    sb.push_back(8'hA3);
    send_byte(8'hA3, 1'b1, DIV);
    hold(10);
    check("beats_a3", n_beats, 2);

    // frame error then 0x81
    send_byte(8'h3C, 1'b0, 30);
    hold(10);
    check("fe_count", n_fe, 1);
    check("fe_beats", n_beats, 2);
    sb.push_back(8'h81);
    send_byte(8'h81, 1'b1, DIV);
    hold(10);
    check("beats_81", n_beats, 3);
    check("sb_empty_81", sb.size(), 0);

    // fill with ready low: cts timing, overrun, ordered drain
    ready = 1'b0;
    beats0 = n_beats;
    ov0 = n_ov;
    for (int i = 0; i < 11; i++) begin
      sb.push_back(8'(i * 37 + 5));
      send_byte(8'(i * 37 + 5), 1'b1, DIV);
    end
    check("ctsn_11", {31'b0, rs232_ctsn}, 32'd0);
    sb.push_back(8'hC9);
    start_frame(8'hC9);
    rs232_txd = 1'b1;
    hold(8);
    hold(1);
    @(negedge clock);
    check("ctsn_push_cycle", {31'b0, rs232_ctsn}, 32'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("ctsn_after_12", {31'b0, rs232_ctsn}, 32'd1);
    hold(DIV);
    for (int i = 12; i < 16; i++) begin
      sb.push_back(8'(i * 29 + 3));
      send_byte(8'(i * 29 + 3), 1'b1, DIV);
    end
    send_byte(8'hEE, 1'b1, DIV);
    hold(5);
    check("overrun_17", n_ov, ov0 + 1);
    check("ctsn_full", {31'b0, rs232_ctsn}, 32'd1);
    check("no_beats_while_held", n_beats, beats0);
    drain();
    check("drain16_beats", n_beats, beats0 + 16);
    check("drain16_sb", sb.size(), 0);
    check("drain16_valid", {31'b0, valid}, 32'd0);
    check("ctsn_drained", {31'b0, rs232_ctsn}, 32'd0);

    // full FIFO, pop coincides with dropped push
    ready = 1'b0;
    beats0 = n_beats;
    ov0 = n_ov;
    for (int i = 0; i < 16; i++) begin
      sb.push_back(8'(i * 53 + 11));
      send_byte(8'(i * 53 + 11), 1'b1, DIV);
    end
    start_frame(8'h5A);
    rs232_txd = 1'b1;
    hold(8);
    ready = 1'b1;
    hold(1);
    ready = 1'b0;
    hold(DIV);
    check("overrun_coinc", n_ov, ov0 + 1);
    check("coinc_pop", n_beats, beats0 + 1);
    check("ctsn_15", {31'b0, rs232_ctsn}, 32'd1);
    drain();
    check("drain15_beats", n_beats, beats0 + 16);
    check("drain15_sb", sb.size(), 0);

    // reset mid data bit 4
    ready = 1'b0;
    for (int i = 0; i < 12; i++) send_byte(8'(i + 100), 1'b1, DIV);
    check("pre_rst_valid", {31'b0, valid}, 32'd1);
    check("pre_rst_ctsn", {31'b0, rs232_ctsn}, 32'd1);
    rs232_txd = 1'b0;
    hold(DIV);
    for (int i = 0; i < 4; i++) begin
      rs232_txd = i[0];
      hold(DIV);
    end
    rs232_txd = 1'b0;
    hold(5);
    resetn = 1'b0;
    #1;
    check("midrst_valid", {31'b0, valid}, 32'd0);
    check("midrst_ctsn", {31'b0, rs232_ctsn}, 32'd0);
    sb.delete();
    rs232_txd = 1'b1;
    hold(3);
    resetn = 1'b1;
    hold(10);
    check("postrst_valid", {31'b0, valid}, 32'd0);
    beats0 = n_beats;
    ready = 1'b1;
    sb.push_back(8'hE7);
    send_byte(8'hE7, 1'b1, DIV);
    hold(20);
    check("postrst_beats", n_beats, beats0 + 1);
    check("postrst_sb", sb.size(), 0);
    check("fe_total", n_fe, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
